// File: rtl/umi_packet_codec.sv
// Registered UMI packet codec: independent pack and unpack paths, one register stage each.
// Optional size checking is enabled by defining UMI_CODEC_SIZE_CHECK_EN (adds pk_err/up_err).
module umi_packet_codec #(
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pk_valid,
    input  logic         pk_write,
    input  logic [6:0]   pk_command,
    input  logic [3:0]   pk_size,
    input  logic [19:0]  pk_options,
    input  logic         pk_burst,
    input  logic [63:0]  pk_dstaddr,
    input  logic [63:0]  pk_srcaddr,
    input  logic [255:0] pk_data,
    output logic [255:0] pk_packet,
    output logic         pk_packet_valid,
`ifdef UMI_CODEC_SIZE_CHECK_EN
    output logic         pk_err,
    output logic         up_err,
`endif
    input  logic         up_valid,
    input  logic [255:0] up_packet,
    input  logic         up_burst,
    output logic         up_out_valid,
    output logic         up_write,
    output logic [6:0]   up_command,
    output logic [3:0]   up_size,
    output logic [19:0]  up_options,
    output logic [63:0]  up_dstaddr,
    output logic [63:0]  up_srcaddr,
    output logic [255:0] up_data
);

    logic [255:0] pk_packet_d, pk_packet_q;
    logic         pk_valid_q;

    logic         up_valid_q;
    logic         up_write_d, up_write_q;
    logic [6:0]   up_command_d, up_command_q;
    logic [3:0]   up_size_d, up_size_q;
    logic [19:0]  up_options_d, up_options_q;
    logic [63:0]  up_dstaddr_d, up_dstaddr_q;
    logic [63:0]  up_srcaddr_d, up_srcaddr_q;
    logic [255:0] up_data_d, up_data_q;

    // Burst packets carry raw data only; header fields are not encoded.
    always_comb begin
        pk_packet_d = pk_data;
        if (!pk_burst) begin
            pk_packet_d = {pk_data[95:0], pk_srcaddr, pk_dstaddr,
                           pk_options, pk_size, pk_command, pk_write};
        end
    end

    always_comb begin
        up_write_d   = 1'b0;
        up_command_d = '0;
        up_size_d    = '0;
        up_options_d = '0;
        up_dstaddr_d = '0;
        up_srcaddr_d = '0;
        up_data_d    = up_packet;
        if (!up_burst) begin
            up_write_d   = up_packet[0];
            up_command_d = up_packet[7:1];
            up_size_d    = up_packet[11:8];
            up_options_d = up_packet[31:12];
            up_dstaddr_d = up_packet[95:32];
            up_srcaddr_d = up_packet[159:96];
            up_data_d    = {160'b0, up_packet[255:160]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_valid_q <= 1'b0;
            if (RESET_CLEAR) pk_packet_q <= '0;
        end else begin
            pk_valid_q <= pk_valid;
            if (pk_valid) pk_packet_q <= pk_packet_d;
        end
    end

    // With RESET_CLEAR = 0 the field registers keep their contents through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid_q <= 1'b0;
            if (RESET_CLEAR) begin
                up_write_q   <= 1'b0;
                up_command_q <= '0;
                up_size_q    <= '0;
                up_options_q <= '0;
                up_dstaddr_q <= '0;
                up_srcaddr_q <= '0;
                up_data_q    <= '0;
            end
        end else begin
            up_valid_q <= up_valid;
            if (up_valid) begin
                up_write_q   <= up_write_d;
                up_command_q <= up_command_d;
                up_size_q    <= up_size_d;
                up_options_q <= up_options_d;
                up_dstaddr_q <= up_dstaddr_d;
                up_srcaddr_q <= up_srcaddr_d;
                up_data_q    <= up_data_d;
            end
        end
    end

`ifdef UMI_CODEC_SIZE_CHECK_EN
    logic pk_err_q, up_err_q;

    // Size above 3 means more than 8 bytes, which the header data field cannot describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pk_err_q <= 1'b0;
            up_err_q <= 1'b0;
        end else begin
            pk_err_q <= pk_valid && !pk_burst && (pk_size > 4'd3);
            up_err_q <= up_valid && !up_burst && (up_packet[11:8] > 4'd3);
        end
    end

    assign pk_err = pk_err_q;
    assign up_err = up_err_q;
`endif

    assign pk_packet       = pk_packet_q;
    assign pk_packet_valid = pk_valid_q;
    assign up_out_valid    = up_valid_q;
    assign up_write        = up_write_q;
    assign up_command      = up_command_q;
    assign up_size         = up_size_q;
    assign up_options      = up_options_q;
    assign up_dstaddr      = up_dstaddr_q;
    assign up_srcaddr      = up_srcaddr_q;
    assign up_data         = up_data_q;

endmodule

// File: tb/tb_umi_packet_codec.sv
// Scoreboard bench for umi_packet_codec: a field-level reference model predicts both paths
// every cycle; a negedge monitor pops the expected queues and compares.
module tb_umi_packet_codec;
    localparam bit RESET_CLEAR = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         pk_valid, pk_write, pk_burst;
    logic [6:0]   pk_command;
    logic [3:0]   pk_size;
    logic [19:0]  pk_options;
    logic [63:0]  pk_dstaddr, pk_srcaddr;
    logic [255:0] pk_data;
    logic [255:0] pk_packet;
    logic         pk_packet_valid;
    logic         pk_err, up_err;
    logic         up_valid, up_burst;
    logic [255:0] up_packet;
    logic         up_out_valid, up_write;
    logic [6:0]   up_command;
    logic [3:0]   up_size;
    logic [19:0]  up_options;
    logic [63:0]  up_dstaddr, up_srcaddr;
    logic [255:0] up_data;

    umi_packet_codec #(.RESET_CLEAR(RESET_CLEAR)) dut (
        .clk(clk), .rst(rst),
        .pk_valid(pk_valid), .pk_write(pk_write), .pk_command(pk_command),
        .pk_size(pk_size), .pk_options(pk_options), .pk_burst(pk_burst),
        .pk_dstaddr(pk_dstaddr), .pk_srcaddr(pk_srcaddr), .pk_data(pk_data),
        .pk_packet(pk_packet), .pk_packet_valid(pk_packet_valid),
`ifdef UMI_CODEC_SIZE_CHECK_EN
        .pk_err(pk_err), .up_err(up_err),
`endif
        .up_valid(up_valid), .up_packet(up_packet), .up_burst(up_burst),
        .up_out_valid(up_out_valid), .up_write(up_write), .up_command(up_command),
        .up_size(up_size), .up_options(up_options), .up_dstaddr(up_dstaddr),
        .up_srcaddr(up_srcaddr), .up_data(up_data)
    );

`ifndef UMI_CODEC_SIZE_CHECK_EN
    assign pk_err = 1'b0;
    assign up_err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         write;
        logic [6:0]   command;
        logic [3:0]   size;
        logic [19:0]  options;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
        logic         err;
    } fields_t;

    typedef struct {
        logic         valid;
        logic [255:0] pkt;
        logic         err;
    } pk_exp_t;

    pk_exp_t pk_q[$];
    fields_t up_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    // Reference state: what each output register should hold right now.
    logic [255:0] pk_pkt_m;
    fields_t      up_m;
    fields_t      rt_prev;
    bit           rt_mode = 0;

    task automatic check(input string name, input logic [415:0] act, input logic [415:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packet built from the layout with plain shifts and masks.
    function automatic logic [255:0] model_pack(input logic w, input logic [6:0] cmd,
            input logic [3:0] sz, input logic [19:0] opt, input logic burst,
            input logic [63:0] dst, input logic [63:0] src, input logic [255:0] data);
        logic [255:0] p;
        logic [255:0] mask96;
        if (burst) return data;
        mask96 = (256'd1 << 96) - 256'd1;
        p = 256'(w);
        p = p | (256'(cmd) << 1) | (256'(sz) << 8) | (256'(opt) << 12);
        p = p | (256'(dst) << 32) | (256'(src) << 96) | ((data & mask96) << 160);
        return p;
    endfunction

    function automatic fields_t model_unpack(input logic [255:0] p, input logic burst);
        fields_t f;
        f.valid = 1'b1;
        f.err   = 1'b0;
        if (burst) begin
            f.write = 0; f.command = 0; f.size = 0; f.options = 0;
            f.dst = 0; f.src = 0; f.data = p;
        end else begin
            f.write   = 1'(p);
            f.command = 7'(p >> 1);
            f.size    = 4'(p >> 8);
            f.options = 20'(p >> 12);
            f.dst     = 64'(p >> 32);
            f.src     = 64'(p >> 96);
            f.data    = p >> 160;
        end
        return f;
    endfunction

    // One clock: predict from the inputs now applied, then queue the prediction at the edge.
    task automatic step();
        pk_exp_t pe;
        fields_t ue;
        bit      size_chk;
`ifdef UMI_CODEC_SIZE_CHECK_EN
        size_chk = 1;
`else
        size_chk = 0;
`endif
        if (rst) begin
            if (RESET_CLEAR) begin
                pk_pkt_m = '0;
                up_m = '{default: '0};
            end
            pe.valid = 0; pe.err = 0;
            up_m.valid = 0; up_m.err = 0;
        end else begin
            pe.valid = pk_valid;
            if (pk_valid)
                pk_pkt_m = model_pack(pk_write, pk_command, pk_size, pk_options, pk_burst,
                                      pk_dstaddr, pk_srcaddr, pk_data);
            pe.err = size_chk && pk_valid && !pk_burst && (pk_size > 3);
            if (up_valid) begin
                if (rt_mode) up_m = rt_prev;
                else up_m = model_unpack(up_packet, up_burst);
            end
            up_m.valid = up_valid;
            up_m.err = size_chk && up_valid && !up_burst && (up_m.size > 3);
        end
        pe.pkt = pk_pkt_m;
        ue = up_m;
        @(posedge clk);
        pk_q.push_back(pe);
        up_q.push_back(ue);
        #1;
    endtask

    always @(negedge clk) begin
        if (pk_q.size() > 0) begin
            pk_exp_t e;
            e = pk_q.pop_front();
            check("pk_packet_valid", 416'(pk_packet_valid), 416'(e.valid));
            check("pk_packet", 416'(pk_packet), 416'(e.pkt));
`ifdef UMI_CODEC_SIZE_CHECK_EN
            check("pk_err", 416'(pk_err), 416'(e.err));
`endif
        end
        if (up_q.size() > 0) begin
            fields_t f;
            f = up_q.pop_front();
            check("up_out_valid", 416'(up_out_valid), 416'(f.valid));
            check("up_fields",
                  {up_write, up_command, up_size, up_options, up_dstaddr, up_srcaddr, up_data},
                  {f.write, f.command, f.size, f.options, f.dst, f.src, f.data});
`ifdef UMI_CODEC_SIZE_CHECK_EN
            check("up_err", 416'(up_err), 416'(f.err));
`endif
        end
    end

    task automatic rand_pk(input bit allow_burst);
        pk_write   = 1'($urandom);
        pk_command = 7'($urandom);
        pk_size    = 4'($urandom);
        pk_options = 20'($urandom);
        pk_burst   = allow_burst ? ($urandom_range(0, 3) == 0) : 1'b0;
        pk_dstaddr = {$urandom, $urandom};
        pk_srcaddr = {$urandom, $urandom};
        pk_data    = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_up();
        up_packet = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        up_burst  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1; pk_valid = 1; up_valid = 1;
        rand_pk(0); rand_up();
        pk_pkt_m = '0;
        up_m = '{default: '0};
        rt_prev = '{default: '0};

        // Reset with valid inputs present: both must be dropped.
        repeat (2) step();
        check("reset_pk_packet", 416'(pk_packet), 416'(0));
        check("reset_up_dstaddr", 416'(up_dstaddr), 416'(0));
        rst = 0;

        // Directed pack and unpack examples.
        pk_valid = 1; pk_write = 1; pk_command = 7'h01; pk_size = 4'd2; pk_options = 0;
        pk_burst = 0; pk_dstaddr = 64'h1000; pk_srcaddr = 0; pk_data = 256'hDEADBEEF;
        up_valid = 1; up_burst = 0; up_packet = '0;
        up_packet[7:0] = 8'h03;
        up_packet[95:32] = 64'h2000_0004;
        up_packet[191:160] = 32'h12345678;
        step();
        check("pack_example", 416'(pk_packet),
              416'({64'h0, 32'hDEADBEEF, 64'h0, 64'h1000, 20'h0, 4'h2, 8'h03}));
        check("unpack_example", {up_write, up_command, up_dstaddr, up_data},
              {1'b1, 7'd1, 64'h2000_0004, 160'h0, 64'h0, 32'h12345678});

        // Burst both ways on an all-ones packet.
        pk_burst = 1; pk_data = '1; up_burst = 1; up_packet = '1;
        step();
        check("burst_pk", 416'(pk_packet), 416'({256{1'b1}}));
        check("burst_up", {up_data, up_dstaddr}, {{256{1'b1}}, 64'h0});

        // Four back-to-back random inputs, then hold.
        for (int i = 0; i < 4; i++) begin
            pk_valid = 1; up_valid = 1; rand_pk(1); rand_up(); step();
        end
        pk_valid = 0; up_valid = 0; rand_pk(1); rand_up();
        repeat (3) step();

        // Size check boundary cases (err predicted only when the feature is built in).
        pk_valid = 1; up_valid = 1; up_packet = '0;
        pk_burst = 0; up_burst = 0; pk_size = 4'd4; up_packet[11:8] = 4'd4; step();
        pk_burst = 1; up_burst = 1; step();
        pk_burst = 0; up_burst = 0; pk_size = 4'd3; up_packet[11:8] = 4'd3; step();

        // Random mix of valids, bursts and idle cycles.
        for (int i = 0; i < 200; i++) begin
            pk_valid = 1'($urandom); up_valid = 1'($urandom);
            rand_pk(1); rand_up(); step();
        end

        // Reset in the middle of traffic.
        rst = 1; pk_valid = 1; up_valid = 1; step();
        rst = 0; pk_valid = 0; up_valid = 0; step();

        // Round trip: the DUT's own packet is fed back into the unpack path.
        rt_mode = 1;
        for (int i = 0; i < 1001; i++) begin
            up_valid  = (i > 0);
            up_burst  = 0;
            up_packet = pk_packet;
            pk_valid  = (i < 1000);
            rand_pk(0);
            step();
            rt_prev.valid = 1; rt_prev.err = 0;
            rt_prev.write = pk_write; rt_prev.command = pk_command; rt_prev.size = pk_size;
            rt_prev.options = pk_options; rt_prev.dst = pk_dstaddr; rt_prev.src = pk_srcaddr;
            rt_prev.data = {160'b0, pk_data[95:0]};
        end
        rt_mode = 0;
        pk_valid = 0; up_valid = 0;
        repeat (2) step();
        @(negedge clk);
        #1;
        check("queues_drained", 416'(pk_q.size() + up_q.size()), 416'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/umi_packet_codec.md
Name: umi_packet_codec

Overview:
- Registered UMI packet codec with two independent paths.
- Pack path: assembles command/size/options/address/data fields into one 256-bit UMI packet.
- Unpack path: splits a 256-bit UMI packet back into its fields.
- Sits between AXI/UMI bridges and UMI links. Each path has one register stage with a valid flag.

Parameters:
- RESET_CLEAR, 1, 1 = packet/field registers cleared to zero on reset; 0 = only valid flags reset, data registers hold.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pk_valid  in  1  pack input fields valid this cycle
- pk_write  in  1  opcode bit 0
- pk_command  in  7  opcode bits 7:1
- pk_size  in  4  log2 of transfer bytes
- pk_options  in  20  user options
- pk_burst  in  1  burst (data-only) packet
- pk_dstaddr  in  64  destination address
- pk_srcaddr  in  64  source/return address
- pk_data  in  256  write data
- pk_packet  out  256  registered packed packet
- pk_packet_valid  out  1  pk_packet valid
- up_valid  in  1  unpack input packet valid
- up_packet  in  256  packet to unpack
- up_burst  in  1  interpret up_packet as burst
- up_out_valid  out  1  unpacked fields valid
- up_write  out  1  unpacked write bit
- up_command  out  7  unpacked command
- up_size  out  4  unpacked size
- up_options  out  20  unpacked options
- up_dstaddr  out  64  unpacked destination address
- up_srcaddr  out  64  unpacked source address
- up_data  out  256  unpacked data

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset:
  - pk_packet_valid = 0 and up_out_valid = 0.
  - With RESET_CLEAR = 1, all other outputs = 0.
- Non-burst packet layout:
  - [0] write
  - [7:1] command
  - [11:8] size
  - [31:12] options
  - [95:32] dstaddr
  - [159:96] srcaddr
  - [255:160] data[95:0]
  - Opcode byte = packet[7:0].
- Burst packet layout: the whole packet = data[255:0]. All other fields are ignored on pack.
- Pack path:
  - On each clk edge with rst = 0: pk_packet_valid <= pk_valid.
  - If pk_valid = 1, pk_packet <= packed value; otherwise pk_packet holds.
  - Latency: 1 cycle.
  - pk_data[255:96] is discarded for non-burst packets.
- Unpack path:
  - up_out_valid <= up_valid.
  - If up_valid = 1, all field outputs update; otherwise they hold.
  - Non-burst: fields extracted per layout; up_data = {160'b0, packet[255:160]}.
  - Burst: up_data = packet; write, command, size, options, dstaddr, srcaddr = 0.
  - Latency: 1 cycle.
- Independence: the paths share no state. Simultaneous pk_valid and up_valid are both processed in the same cycle.
- Flow control: none. A valid input is accepted every cycle; back-to-back inputs give back-to-back outputs.
- Reset mid-operation: a valid input in the reset cycle is dropped; both valid outputs are 0 the next cycle.
- Round trip: unpack(pack(x)) returns x for every non-burst field, with data truncated to 96 bits.

Optional Feature:
- Macro UMI_CODEC_SIZE_CHECK_EN.
- When defined, adds two outputs:
  - pk_err  out  1: registered alongside pk_packet.
  - up_err  out  1: registered alongside up_out_valid.
- Each err is set when the corresponding valid input is non-burst and size > 3 (transfer longer than 8 bytes; data field not a power-of-two fit).
- Each err is 0 when its input valid is 0; reset value 0.
- Packing and unpacking are otherwise unchanged; the packet is still produced.
- When undefined: these ports and their logic do not exist.

Test Plan:
- Reset: assert rst for 2 cycles with pk_valid = up_valid = 1 -> both valid outputs 0; with RESET_CLEAR = 1, pk_packet = 0 and up_dstaddr = 0.
- Pack non-burst:
  - Stimulus: write=1, command=7'h01, size=2, options=0, dstaddr=64'h1000, srcaddr=0, data=32'hDEADBEEF.
  - Next cycle: pk_packet[7:0]=8'h03, [11:8]=2, [95:32]=64'h1000, [191:160]=32'hDEADBEEF, all other bits 0, pk_packet_valid = 1.
- Unpack read response:
  - Stimulus: packet with opcode 8'h03, dstaddr=64'h2000_0004, data=32'h12345678, up_burst=0.
  - Next cycle: up_write=1, up_command=1, up_dstaddr=64'h2000_0004, up_data[31:0]=32'h12345678, up_data[255:96]=0.
- Burst both ways:
  - pk_burst=1, pk_data=all-ones -> pk_packet all-ones.
  - up_burst=1 on the same packet -> up_data all-ones, up_dstaddr=0.
- Back-to-back and hold:
  - 4 consecutive random pack/unpack inputs, then valid=0 -> outputs match each input one cycle later, then hold the last values with valid=0.
  - Random round trip: 1000 non-burst field sets -> unpack(pack(x)) equals x.
- With UMI_CODEC_SIZE_CHECK_EN:
  - size=4, burst=0 -> pk_err=1 and up_err=1.
  - size=4, burst=1 -> pk_err=0 and up_err=0.
  - size=3, burst=0 -> pk_err=0 and up_err=0.
